// File: rtl/corescore_uart_pkg.sv
// rtl/corescore_uart_pkg.sv - shared types and constants for the CoreScore UART transmitter
// Optional feature macro: CORESCORE_UART_PARITY_EN (adds an odd-parity bit, 8O1 framing)
package corescore_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int DATA_BITS = 8;

`ifdef CORESCORE_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Clock cycles per bit; floor division, callers must keep the result >= 2.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/corescore_baud_gen.sv
// rtl/corescore_baud_gen.sv - bit-period counter with restart, ticks on the last cycle of each bit
module corescore_baud_gen #(
  parameter int DIV = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_bit_end
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  assign o_bit_end = (cnt_q == LAST);

  // Count 0..DIV-1 within a bit; held at zero while restarted so a new state starts a fresh bit.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      cnt_q <= '0;
    end else if (o_bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/corescore_uart_tx.sv
// rtl/corescore_uart_tx.sv - byte stream to UART serialiser with end-of-message strobe
// Optional feature macro: CORESCORE_UART_PARITY_EN (odd parity bit between data and stop)
module corescore_uart_tx
  import corescore_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 16_000_000,
  parameter int BAUD        = 57_600
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tdata,
  input  logic       i_tlast,
  input  logic       i_tvalid,
  output logic       o_tready,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_msg_done
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        tlast_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
`ifdef CORESCORE_UART_PARITY_EN
  logic        parity_q;
`endif
  logic        bit_end;
  logic        baud_restart;

  // The baud counter idles at zero, so the first START cycle is count 0.
  assign baud_restart = (state_q == IDLE);

  corescore_baud_gen #(
    .DIV(DIV)
  ) u_baud_gen (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (baud_restart),
    .o_bit_end (bit_end)
  );

  // Ready depends only on the registered state and reset, never on tvalid.
  assign o_tready   = (state_q == IDLE) && !i_rst;
  assign o_uart_tx  = tx_q;
  assign o_busy     = busy_q;
  assign o_msg_done = done_q;

  // Frame sequencer: every output is registered and updated together with the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tlast_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CORESCORE_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_tvalid) begin
            shift_q   <= i_tdata;
            tlast_q   <= i_tlast;
`ifdef CORESCORE_UART_PARITY_EN
            parity_q  <= ~^i_tdata;
`endif
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == LAST_BIT) begin
`ifdef CORESCORE_UART_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              // Shift right so the next data bit is always at position 1 before it is sent.
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end
        end
`ifdef CORESCORE_UART_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= tlast_q;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
